// File: rtl/vga_scan_gen.sv
// 640x480@60 VGA scan generator presenting a pixel-doubled, horizontally centred 256x240 game window.
// Build macro TEST_PATTERN_EN replaces the returned image with 8 vertical colour bars inside the window.

module vga_scan_gen #(
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int X_OFS   = 64,
  parameter int LAT     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] image,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic       EN,
  output logic       frame_start,
  output logic [2:0] vga_rgb,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int WIN_W  = 512;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

`ifdef TEST_PATTERN_EN
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic       win;
    logic [2:0] bar;
  } stage_t;
  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, win: 1'b0, bar: 3'd0};
`else
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic win;
  } stage_t;
  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, win: 1'b0};
`endif

  logic [DIV_W-1:0] divider;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             win_nxt;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  stage_t           raw;
  stage_t           tap;

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= 10'(X_OFS)) && (h < 10'(X_OFS + WIN_W)) && (v < 10'(V_VIS));
  endfunction

  assign tick = (divider == DIV_W'(PIX_DIV - 1));

  // NOTE: every signal in a combinational block gets a default first, so no latch can be inferred.
  always_comb begin
    h_wrap = (hcnt == 10'(H_TOT - 1));
    v_wrap = (vcnt == 10'(V_TOT - 1));
    h_nxt  = h_wrap ? 10'd0 : hcnt + 10'd1;
    v_nxt  = vcnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : vcnt + 10'd1;
    end
    win_nxt = in_window(h_nxt, v_nxt);
  end

  // Raw timing for the pixel currently being scanned; it enters the alignment pipe on the next tick.
  always_comb begin
    raw     = STAGE_IDLE;
    raw.hs  = !((hcnt >= 10'(HS_BEG)) && (hcnt < 10'(HS_END)));
    raw.vs  = !((vcnt >= 10'(VS_BEG)) && (vcnt < 10'(VS_END)));
    raw.vis = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));
    raw.win = in_window(hcnt, vcnt);
`ifdef TEST_PATTERN_EN
    raw.bar = 3'((hcnt - 10'(X_OFS)) >> 6);
`endif
  end

  // The output registers form the last alignment stage, so only LAT-1 stages live here.
  if (LAT > 1) begin : g_pipe
    stage_t pipe [LAT-1];

    // NOTE: the alignment stages are reset like ordinary flops so no stale sync reaches the pins.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < LAT - 1; i++) begin
          pipe[i] <= STAGE_IDLE;
        end
      end else if (tick) begin
        pipe[0] <= raw;
        for (int i = 1; i < LAT - 1; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign tap = pipe[LAT-2];
  end else begin : g_no_pipe
    assign tap = raw;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      divider     <= '0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      col         <= 8'd0;
      row         <= 8'd0;
      EN          <= 1'b0;
      frame_start <= 1'b0;
      vga_rgb     <= 3'b000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
    end else begin
      frame_start <= tick && h_wrap && v_wrap;
      divider     <= tick ? '0 : divider + DIV_W'(1);
      if (tick) begin
        hcnt  <= h_nxt;
        vcnt  <= v_nxt;
        EN    <= win_nxt;
        col   <= win_nxt ? 8'((h_nxt - 10'(X_OFS)) >> 1) : 8'd0;
        row   <= win_nxt ? 8'(v_nxt >> 1) : 8'd0;
        hsync <= tap.hs;
        vsync <= tap.vs;
`ifdef TEST_PATTERN_EN
        vga_rgb <= (tap.win && tap.vis) ? tap.bar : 3'b000;
`else
        vga_rgb <= (tap.win && tap.vis) ? image : 3'b000;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: directed window/latency points plus randomized-image
// streams compared every clock against an arithmetic model of the scan timing.

module tb_vga_scan_gen;

  localparam int PIX_DIV = 2;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  // Short vertical frame keeps multi-frame runs brief; horizontal timing is the real one.
  localparam int V_VIS   = 4;
  localparam int V_FP    = 2;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam int X_OFS   = 64;
  localparam int LAT     = 2;

  localparam int H_TOT       = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT       = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_TICKS = H_TOT * V_TOT;
  localparam int LINE_CLK    = H_TOT * PIX_DIV;
  localparam int FRAME_CLK   = FRAME_TICKS * PIX_DIV;
  localparam int HIST        = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] image = 3'b000;
  logic [7:0] col;
  logic [7:0] row;
  logic       EN;
  logic       frame_start;
  logic [2:0] vga_rgb;
  logic       hsync;
  logic       vsync;

  int         checks   = 0;
  int         errors   = 0;
  int         n        = 0;
  bit         rand_img = 1'b0;
  logic [2:0] img_hist [HIST];

  typedef struct {
    logic [7:0] col;
    logic [7:0] row;
    logic       en;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } exp_t;

  vga_scan_gen #(
    .PIX_DIV(PIX_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .X_OFS(X_OFS), .LAT(LAT)
  ) dut (
    .clock(clock), .reset(reset), .image(image), .col(col), .row(row), .EN(EN),
    .frame_start(frame_start), .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync)
  );

  always #5 clock = ~clock;

  // Clock edges since reset release, and the image value present at every pixel tick.
  always @(posedge clock) begin
    if (reset) begin
      n <= 0;
    end else begin
      n <= n + 1;
      if ((n + 1) % PIX_DIV == 0) img_hist[((n + 1) / PIX_DIV) % HIST] <= image;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (rand_img) image = 3'($urandom_range(0, 7));
    end
  end

  function automatic bit in_win(input int h, input int v);
    return (h >= X_OFS) && (h < X_OFS + 512) && (v < V_VIS);
  endfunction

  // Expected outputs after cnt clocks since reset release.
  function automatic exp_t model(input int cnt);
    exp_t e;
    int p, h, v, pd, hd, vd;
    p     = cnt / PIX_DIV;
    h     = p % H_TOT;
    v     = (p / H_TOT) % V_TOT;
    e.en  = in_win(h, v);
    e.col = e.en ? 8'((h - X_OFS) / 2) : 8'd0;
    e.row = e.en ? 8'(v / 2) : 8'd0;
    e.fs  = (cnt > 0) && (cnt % PIX_DIV == 0) && (p % FRAME_TICKS == 0);
    pd    = p - LAT;
    if (pd < 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 3'b000;
    end else begin
      hd   = pd % H_TOT;
      vd   = (pd / H_TOT) % V_TOT;
      e.hs = !((hd >= H_VIS + H_FP) && (hd < H_VIS + H_FP + H_SYNC));
      e.vs = !((vd >= V_VIS + V_FP) && (vd < V_VIS + V_FP + V_SYNC));
      if (!in_win(hd, vd)) e.rgb = 3'b000;
`ifdef TEST_PATTERN_EN
      else e.rgb = 3'((hd - X_OFS) / 64);
`else
      else e.rgb = img_hist[p % HIST];
`endif
    end
    return e;
  endfunction

  // Value expected on vga_rgb for a lit window pixel while image is held at 3'b101.
  function automatic logic [2:0] lit(input int cnt);
`ifdef TEST_PATTERN_EN
    return 3'((((cnt / PIX_DIV) - LAT) % H_TOT - X_OFS) / 64);
`else
    return (cnt >= 0) ? 3'b101 : 3'b101;
`endif
  endfunction

  task automatic wait_n(input int target);
    int guard = 0;
    while (n < target && guard <= target + 4) begin
      @(negedge clock);
      guard++;
    end
    if (n != target) begin
      checks++;
      errors++;
      $display("FAIL wait_n: reached n=%0d, required n=%0d", n, target);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rand_img = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    checks += 7;
    if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b, want 1", hsync); end
    if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b, want 1", vsync); end
    if (EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, want 0", EN); end
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b, want 000", vga_rgb); end
    if (col !== 8'd0) begin errors++; $display("FAIL reset_col: got %0d, want 0", col); end
    if (row !== 8'd0) begin errors++; $display("FAIL reset_row: got %0d, want 0", row); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b, want 0", frame_start); end
    reset = 1'b0;
  endtask

  // Window mapping and image latency with image held at 3'b101.
  task automatic test_window_latency();
    rand_img = 1'b0;
    image    = 3'b101;
    apply_reset();
    wait_n(128);  checks++;
    if ({EN, col, row} !== {1'b1, 8'd0, 8'd0}) begin errors++;
      $display("FAIL win_first: EN=%b col=%0d row=%0d, want 1/0/0", EN, col, row); end
    wait_n(131);  checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL lat_before: rgb=%b, want 000", vga_rgb); end
    wait_n(132);  checks++;
    if ({EN, col, vga_rgb} !== {1'b1, 8'd1, lit(132)}) begin errors++;
      $display("FAIL win_col1: EN=%b col=%0d rgb=%b, want 1/1/%b", EN, col, vga_rgb, lit(132)); end
    wait_n(1150); checks++;
    if ({EN, col, row, vga_rgb} !== {1'b1, 8'd255, 8'd0, lit(1150)}) begin errors++;
      $display("FAIL win_last_col: EN=%b col=%0d row=%0d rgb=%b", EN, col, row, vga_rgb); end
    wait_n(1152); checks++;
    if ({EN, col, vga_rgb} !== {1'b0, 8'd0, lit(1152)}) begin errors++;
      $display("FAIL win_exit: EN=%b col=%0d rgb=%b, want 0/0/%b", EN, col, vga_rgb, lit(1152)); end
    wait_n(1155); checks++;
    if (vga_rgb !== lit(1155)) begin errors++; $display("FAIL lat_last: rgb=%b, want %b", vga_rgb, lit(1155)); end
    wait_n(1156); checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL lat_after: rgb=%b, want 000", vga_rgb); end
    wait_n(1400); checks++;
    if (vga_rgb !== 3'b000) begin errors++; $display("FAIL blank_h: rgb=%b, want 000", vga_rgb); end
    wait_n(1732); checks++;
    if ({EN, col, row, vga_rgb} !== {1'b1, 8'd1, 8'd0, lit(1732)}) begin errors++;
      $display("FAIL line1: EN=%b col=%0d row=%0d rgb=%b", EN, col, row, vga_rgb); end
    wait_n(3328); checks++;
    if ({EN, col, row} !== {1'b1, 8'd0, 8'd1}) begin errors++;
      $display("FAIL line2_row: EN=%b col=%0d row=%0d, want 1/0/1", EN, col, row); end
    wait_n(5950); checks++;
    if ({EN, col, row} !== {1'b1, 8'd255, 8'd1}) begin errors++;
      $display("FAIL win_corner: EN=%b col=%0d row=%0d, want 1/255/1", EN, col, row); end
    wait_n(5952); checks++;
    if ({EN, col, row} !== {1'b0, 8'd0, 8'd0}) begin errors++;
      $display("FAIL corner_exit: EN=%b col=%0d row=%0d, want 0/0/0", EN, col, row); end
    wait_n(6532); checks++;
    if ({EN, vga_rgb} !== {1'b0, 3'b000}) begin errors++;
      $display("FAIL blank_v: EN=%b rgb=%b, want 0/000", EN, vga_rgb); end
  endtask

  // Every-clock model comparison plus sync/frame period measurements; starts right after reset release.
  task automatic test_stream(input int cycles, input string tag);
    exp_t e;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;
    int   hs_fall = -1, vs_fall = -1, fs_at = -1, hs_cnt = 0, fs_cnt = 0, exp_hs, exp_fs;
    int   first_h = (H_VIS + H_FP + LAT) * PIX_DIV;
    int   first_v = ((V_VIS + V_FP) * H_TOT + LAT) * PIX_DIV;
    rand_img = 1'b1;
    repeat (cycles) begin
      @(negedge clock);
      e = model(n);
      checks++;
      if ({col, row, EN, frame_start, hsync, vsync, vga_rgb} !== {e.col, e.row, e.en, e.fs, e.hs, e.vs, e.rgb}) begin
        errors++;
        $display("FAIL %s n=%0d: col=%0d row=%0d EN=%b fs=%b hs=%b vs=%b rgb=%b, want col=%0d row=%0d EN=%b fs=%b hs=%b vs=%b rgb=%b",
                 tag, n, col, row, EN, frame_start, hsync, vsync, vga_rgb,
                 e.col, e.row, e.en, e.fs, e.hs, e.vs, e.rgb);
      end
      if (prev_hs === 1'b1 && hsync === 1'b0) begin
        checks++;
        if (hs_fall < 0 && n != first_h) begin errors++;
          $display("FAIL %s hs_first_fall: at %0d, want %0d", tag, n, first_h); end
        else if (hs_fall >= 0 && n - hs_fall != LINE_CLK) begin errors++;
          $display("FAIL %s hs_period: %0d, want %0d", tag, n - hs_fall, LINE_CLK); end
        hs_fall = n;
        hs_cnt++;
      end
      if (prev_hs === 1'b0 && hsync === 1'b1) begin
        checks++;
        if (n - hs_fall != H_SYNC * PIX_DIV) begin errors++;
          $display("FAIL %s hs_width: %0d, want %0d", tag, n - hs_fall, H_SYNC * PIX_DIV); end
      end
      if (prev_vs === 1'b1 && vsync === 1'b0) begin
        checks++;
        if (vs_fall < 0 && n != first_v) begin errors++;
          $display("FAIL %s vs_first_fall: at %0d, want %0d", tag, n, first_v); end
        else if (vs_fall >= 0 && n - vs_fall != FRAME_CLK) begin errors++;
          $display("FAIL %s vs_period: %0d, want %0d", tag, n - vs_fall, FRAME_CLK); end
        vs_fall = n;
      end
      if (prev_vs === 1'b0 && vsync === 1'b1) begin
        checks++;
        if (n - vs_fall != V_SYNC * LINE_CLK) begin errors++;
          $display("FAIL %s vs_width: %0d, want %0d", tag, n - vs_fall, V_SYNC * LINE_CLK); end
      end
      if (frame_start === 1'b1) begin
        checks++;
        if (prev_fs === 1'b1) begin errors++; $display("FAIL %s fs_width: high again at %0d, want 1 clock", tag, n); end
        else if (fs_at < 0 && n != FRAME_CLK) begin errors++;
          $display("FAIL %s fs_first: at %0d, want %0d", tag, n, FRAME_CLK); end
        else if (fs_at >= 0 && n - fs_at != FRAME_CLK) begin errors++;
          $display("FAIL %s fs_spacing: %0d, want %0d", tag, n - fs_at, FRAME_CLK); end
        fs_at = n;
        fs_cnt++;
      end
      prev_hs = hsync;
      prev_vs = vsync;
      prev_fs = frame_start;
    end
    exp_hs = (n >= first_h) ? 1 + (n - first_h) / LINE_CLK : 0;
    exp_fs = n / FRAME_CLK;
    checks += 2;
    if (hs_cnt != exp_hs) begin errors++; $display("FAIL %s hs_count: %0d, want %0d", tag, hs_cnt, exp_hs); end
    if (fs_cnt != exp_fs) begin errors++; $display("FAIL %s fs_count: %0d, want %0d", tag, fs_cnt, exp_fs); end
  endtask

  // Reset while both sync pulses are active, then the restart must match power-up timing.
  task automatic test_mid_reset();
    exp_t e;
    int   target = PIX_DIV * ((V_VIS + V_FP) * H_TOT + 700);
    apply_reset();
    rand_img = 1'b1;
    wait_n(target);
    e = model(n);
    checks++;
    if ({hsync, vsync} !== {e.hs, e.vs}) begin errors++;
      $display("FAIL pre_reset_sync: hs=%b vs=%b, want %b %b", hsync, vsync, e.hs, e.vs); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({hsync, vsync, EN, col, row, vga_rgb, frame_start} !== {1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: hs=%b vs=%b EN=%b col=%0d row=%0d rgb=%b fs=%b, want 1 1 0 0 0 000 0",
               hsync, vsync, EN, col, row, vga_rgb, frame_start);
    end
    reset = 1'b0;
    test_stream(FRAME_CLK + 100, "post_reset");
  endtask

  initial begin
    test_reset();
    test_window_latency();
    apply_reset();
    test_stream(2 * FRAME_CLK + 100, "stream");
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- 640x480@60 VGA timing generator. It is the initiator side of the pixel-request interface: it drives col/row/EN to the sprite compositor and receives its 3-bit image pixel back.
- Presents a 256x240 logical game window, pixel-doubled to 512x480 and centred horizontally.
- Aligns the returned pixel with delayed sync and blank, then drives the VGA connector pins.
- Sits at the top level between the clock source, the image compositor and the board VGA pins.

Parameters:
- PIX_DIV, 2: system clocks per VGA pixel (50 MHz to 25 MHz).
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing, in pixels.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing, in lines.
- X_OFS, 64: first visible pixel of the game window.
- LAT, 2: pixel ticks from col/row presentation to the matching image sample.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- image  in  3  {R,G,B} pixel returned by the compositor
- col  out  8  logical column 0..255
- row  out  8  logical row 0..239
- EN  out  1  col/row valid; high inside the game window
- frame_start  out  1  one-clock pulse at the start of each frame
- vga_rgb  out  3  pixel to the DAC pins
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: divider=0, hcnt=0, vcnt=0, col=0, row=0, EN=0, frame_start=0, vga_rgb=0, hsync=1, vsync=1. All LAT pipeline stages are cleared to blank/no-sync.
- Reset mid-frame: restarts at hcnt=0, vcnt=0 on the next clock. No partial sync pulse is emitted after reset.
- Tick generation: divider counts 0..PIX_DIV-1. tick is high when divider==PIX_DIV-1. All counters and outputs (except frame_start) update only on tick.
- hcnt: counts 0..799, wraps to 0.
- vcnt: increments when hcnt wraps; counts 0..524, wraps to 0.
- Game window: H_w = X_OFS<=hcnt<X_OFS+512 and vcnt<480.
  - Inside the window: col=(hcnt-X_OFS)>>1, row=vcnt>>1, EN=1 (all registered).
  - Outside the window: col=0, row=0, EN=0.
- Each logical pixel is presented for 2 ticks and each logical row for 2 lines. col=255,row=239 is last presented at hcnt=575, vcnt=479.
- Raw sync:
  - hs_raw low for 656<=hcnt<752.
  - vs_raw low for 490<=vcnt<492.
  - vis_raw = hcnt<640 && vcnt<480.
  - win_raw = H_w.
- Alignment: hs/vs/vis/win_raw pass through a LAT-stage shift register clocked on tick.
  - hsync and vsync are the stage-LAT values.
  - On tick, vga_rgb = image if delayed win, else 3'b000 (the border and blanking regions are black).
- frame_start: high for exactly one clock on the clock after the tick that sets hcnt=0, vcnt=0. It is not asserted on the first frame after reset.
- Widths: hcnt and vcnt are 10 bits. The col subtraction is done at 10 bits and then truncated after the shift. No overflow is possible.

Optional Feature:
- Macro TEST_PATTERN_EN.
  - When defined: inside the window, vga_rgb = col[7:5] (8 vertical colour bars of 32 logical pixels), and image is ignored. EN, col and row are still driven normally.
  - When undefined: the image path only; no extra logic.

Test Plan:
- Reset: assert reset for 3 clocks -> hsync=1, vsync=1, EN=0, vga_rgb=0, col=0, row=0. The first hsync fall occurs (656+LAT)*2 = 1316 clocks after reset release.
- Line/frame timing: run 2 frames -> hsync period 1600 clocks, low 192 clocks. vsync period 840000 clocks, low 3200 clocks. frame_start pulse spacing 840000 clocks, each pulse 1 clock wide.
- Window mapping:
  - hcnt=64, vcnt=0 -> col=0, row=0, EN=1.
  - hcnt=66 -> col=1.
  - hcnt=575, vcnt=479 -> col=255, row=239.
  - hcnt=576 -> EN=0, col=0.
- Latency: image held at 3'b101 -> vga_rgb=101 exactly from tick hcnt=64+LAT through hcnt=575+LAT, and 000 elsewhere, including hcnt 640..799 and vcnt>=480.
- Mid-frame reset: assert reset at vcnt=200, hcnt=300 -> next clock counters=0, hsync=1, vsync=1. Subsequent timing is identical to the post-power-up timing.
- TEST_PATTERN_EN defined: image=3'b111 -> vga_rgb=000 for col 0..31, 001 for col 32..63, ..., 111 for col 224..255.
